fib_req_sched: RTL
==================

Name: fib_req_sched

Overview:
- Round-robin scheduler that shares one iterative Fibonacci engine between NREQ requesters.
- Accepts one request (index n) at a time, sequences the engine, and returns the result tagged with the requester id.
- Hardware counterpart to the DPI fibonacci model; the model serves as its golden reference.
- Convention: fib(0)=0, fib(1)=fib(2)=1, fib(46)=1836311903.

Parameters:
- NREQ, 4, number of requesters (2..8).
- NW, 8, width of the requested index n.
- DW, 32, result width.
- N_MAX, 46, largest legal n. Any n > N_MAX is an error.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_n  in  NREQ*NW  flattened indices; requester i uses bits [i*NW +: NW].
- req_ready  out  NREQ  one-hot accept strobe.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer ready.
- rsp_id  out  $clog2(NREQ)  id of the requester that owns the result.
- rsp_data  out  DW  fib(n), or 0 on error.
- rsp_err  out  1  n > N_MAX.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset: sampled at a rising clock edge with reset_n=0.
  - Outputs req_ready, rsp_valid, rsp_id, rsp_data, rsp_err and busy all go to 0.
  - State goes to IDLE, rr pointer to 0, engine is aborted.
  - Reset asserted mid-COMPUTE or mid-RESP discards the in-flight request; no response is produced.
- FSM states: IDLE, COMPUTE, RESP.
- IDLE:
  - req_ready is the one-hot grant, combinational from req_valid and the rr pointer.
  - Grant goes to the first valid requester searching from the pointer upward, with wrap.
  - req_ready is 0 in every other state.
  - On handshake (valid & ready), latch n and id, then set pointer = (grant+1) mod NREQ.
  - n=0: go to RESP with data 0, err 0.
  - n>N_MAX: go to RESP with data 0, err 1.
  - Otherwise: start the engine and go to COMPUTE.
- COMPUTE:
  - Engine registers (a,b) load (0,1) at accept.
  - Each cycle (a,b) <= (b, a+b) while remaining count > 0.
  - After n iterations a = fib(n); go to RESP.
  - Arithmetic is DW-bit unsigned. No overflow is reachable because N_MAX=46 fits in 32 bits.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err stay stable until rsp_valid & rsp_ready.
  - After the handshake, return to IDLE; rsp_valid drops the next cycle.
- Latency, from the accept edge to first rsp_valid: n+1 cycles for 1<=n<=N_MAX; 1 cycle for n=0 or n>N_MAX.
- rsp_ready already high when rsp_valid rises: the transfer completes on that edge.
- There is always at least one IDLE cycle between a response transfer and the next accept.
- A requester must hold req_valid and req_n stable until it sees req_ready.
- Requests that are not granted are not dropped; they wait.
- A requester that reasserts immediately after its own grant gets lowest priority in the next arbitration.

Optional Feature:
- Macro: FIB_RESULT_CACHE_EN.
- Defined:
  - A single-entry cache holds {valid, n, result} of the last successful computation.
  - An accepted request with n equal to the cached n, and the cache valid, goes directly to RESP with the cached data.
  - Latency for a cache hit is 1 cycle.
  - The cache is cleared by reset. Error responses are never cached.
- Not defined: no cache logic; every legal n ≥ 1 goes through COMPUTE.

Decomposition:
- Package fib_pkg:
  - FIB_N_MAX = 46.
  - typedef fib_t (logic [31:0]).
  - typedef fib_idx_t (logic [7:0]).
  - Enum sched_state_e {IDLE, COMPUTE, RESP}.
- Sub-module fib_engine:
  - Ports: clock, reset_n, start, n, busy, done (1-cycle pulse), result.
  - Holds the (a,b) registers and the down-counter.
  - The scheduler owns arbitration, the FSM, the response registers and the optional cache.

Test Plan:
1. Requester 0 sends n=1 with rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_id=0, rsp_data=1, rsp_err=0.
2. Requester 2 sends n=46 → after 47 cycles rsp_data=1836311903. Sweep n=1..46 and compare every result against the DPI fibonacci model: 0 mismatches.
3. Send n=0 → 1 cycle later rsp_data=0, err=0. Send n=47 and n=255 → rsp_err=1, rsp_data=0, no COMPUTE cycles.
4. All four requesters hold n=10 from reset → grants in order 0,1,2,3, each with rsp_data=55. Then requesters 1 and 3 only → order 1,3.
5. n=20 with rsp_ready held low for 5 cycles → rsp_valid, rsp_id and rsp_data=6765 stable throughout; req_ready=0 throughout.
6. reset_n=0 for one cycle mid-COMPUTE of n=30 → next cycle all outputs 0. A following n=30 from requester 1 returns 832040 with no stale response. With FIB_RESULT_CACHE_EN, a repeat n=30 hits in 1 cycle.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci request scheduler and its engine.
package fib_pkg;

  localparam int FIB_N_MAX = 46;

  typedef logic [31:0] fib_t;
  typedef logic [7:0]  fib_idx_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } sched_state_e;

endpackage

// File: rtl/fib_engine.sv
// Iterative Fibonacci engine: (a,b) <= (b, a+b) once per cycle for n iterations.
// done pulses in the cycle whose closing edge performs the last iteration; result is valid with it.
module fib_engine
  import fib_pkg::*;
#(
  parameter int NW = $bits(fib_idx_t),
  parameter int DW = $bits(fib_t)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          start,
  input  logic [NW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result
);

  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      a_d    = '0;
      b_d    = DW'(1);
      cnt_d  = n;
      busy_d = (n != '0);
    end else if (busy_q) begin
      a_d    = b_q;
      b_d    = a_q + b_q;
      cnt_d  = cnt_q - NW'(1);
      busy_d = (cnt_q != NW'(1));
    end
    // Flag the final iteration one cycle ahead so the scheduler can act on that edge.
    done_d = busy_d && (cnt_d == NW'(1));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // With one iteration left, b already holds the value a is about to take: fib(n).
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = b_q;

endmodule

// File: rtl/fib_req_sched.sv
// Round-robin scheduler sharing one Fibonacci engine among NREQ requesters.
// Optional single-entry result cache enabled by defining FIB_RESULT_CACHE_EN.
module fib_req_sched
  import fib_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NW    = 8,
  parameter int DW    = 32,
  parameter int N_MAX = FIB_N_MAX
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*NW-1:0]       req_n,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DW-1:0]            rsp_data,
  output logic                     rsp_err,
  output logic                     busy
);

  localparam int IDW = $clog2(NREQ);

  sched_state_e   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d, rsp_id_q, rsp_id_d, grant_id;
  logic [DW-1:0]  rsp_data_q, rsp_data_d, eng_result, cache_data;
  logic           rsp_err_q, rsp_err_d;
  logic           grant_found, eng_start, eng_busy, eng_done, cache_hit;
  logic [NW-1:0]  sel_n;

  // First valid requester at or after the pointer, wrapping.
  always_comb begin : arbiter
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_id    = '0;
    sel_n       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = IDW'(idx);
        sel_n       = req_n[idx*NW +: NW];
      end
    end
  end

  always_comb begin : fsm
    state_d    = state_q;
    ptr_d      = ptr_q;
    rsp_id_d   = rsp_id_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = '0;
    eng_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          req_ready[grant_id] = 1'b1;
          rsp_id_d            = grant_id;
          ptr_d               = IDW'((int'(grant_id) + 1) % NREQ);
          rsp_data_d          = '0;
          rsp_err_d           = 1'b0;
          state_d             = RESP;
          if (sel_n > NW'(N_MAX)) begin
            rsp_err_d = 1'b1;
          end else if (cache_hit) begin
            rsp_data_d = cache_data;
          end else if (sel_n != '0) begin
            eng_start = 1'b1;
            state_d   = COMPUTE;
          end
        end
      end
      COMPUTE: begin
        if (eng_done) begin
          rsp_data_d = eng_result;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rsp_id_q   <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rsp_id_q   <= rsp_id_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

`ifdef FIB_RESULT_CACHE_EN
  logic          cache_v_q, cache_v_d;
  logic [NW-1:0] cache_n_q, cache_n_d, n_q, n_d;
  logic [DW-1:0] cache_data_q, cache_data_d;

  // Only engine results are cached, so errors and n=0 never land here.
  always_comb begin
    n_d          = (state_q == IDLE && grant_found) ? sel_n : n_q;
    cache_v_d    = cache_v_q;
    cache_n_d    = cache_n_q;
    cache_data_d = cache_data_q;
    if (state_q == COMPUTE && eng_done) begin
      cache_v_d    = 1'b1;
      cache_n_d    = n_q;
      cache_data_d = eng_result;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      n_q          <= '0;
      cache_v_q    <= 1'b0;
      cache_n_q    <= '0;
      cache_data_q <= '0;
    end else begin
      n_q          <= n_d;
      cache_v_q    <= cache_v_d;
      cache_n_q    <= cache_n_d;
      cache_data_q <= cache_data_d;
    end
  end

  assign cache_hit  = cache_v_q && (sel_n == cache_n_q);
  assign cache_data = cache_data_q;
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  fib_engine #(
    .NW(NW),
    .DW(DW)
  ) u_engine (
    .clock  (clock),
    .reset_n(reset_n),
    .start  (eng_start),
    .n      (sel_n),
    .busy   (eng_busy),
    .done   (eng_done),
    .result (eng_result)
  );

  assign rsp_valid = (state_q == RESP);
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE) || eng_busy;

endmodule
